// File: rtl/cic_pkg.sv
// cic_pkg: width helpers shared by the CIC decimator blocks
package cic_pkg;
    function automatic int clog2(input logic [127:0] v);
        int k;
        k = 0;
        for (int i = 0; i < 128; i++)
            if ((128'd1 << i) < v) k = i + 1;
        return k;
    endfunction
    // Full-precision internal width: input bits plus log2 of the DC gain (R*M)^N
    function automatic int calc_w(input int inp_dw, input int r, input int m, input int n);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < n; i++) p = p * 128'(r * m);
        return inp_dw + clog2(p);
    endfunction
endpackage

// File: rtl/cic_decim_core_if.sv
// cic_decim_core_if: signed sample bus with a one-cycle valid strobe
interface cic_decim_core_if #(parameter int DW = 18);
    logic signed [DW-1:0] data;
    logic                 str;
    modport master (output data, output str);
    modport slave  (input data, input str);
endinterface

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: y = x - x[n-M] over an M-deep delay line, updated on strobe
module cic_comb_stage #(parameter int W = 32, parameter int M = 1) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                str,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);
    logic signed [W-1:0] dly_d [M];
    logic signed [W-1:0] dly_q [M];
    logic signed [W-1:0] y_d, y_q;
    always_comb begin
        y_d = str ? x - dly_q[M-1] : y_q;
        dly_d[0] = str ? x : dly_q[0];
        for (int i = 1; i < M; i++) dly_d[i] = str ? dly_q[i-1] : dly_q[i];
    end
    always_ff @(posedge clk)
        if (!reset_n || clear) begin
            y_q   <= '0;
            dly_q <= '{default: '0};
        end else begin
            y_q   <= y_d;
            dly_q <= dly_d;
        end
    assign y = y_q;
endmodule

// File: rtl/cic_integrator_stage.sv
// cic_integrator_stage: wrapping W-bit accumulator advanced on each input strobe
module cic_integrator_stage #(parameter int W = 32) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                str,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] acc
);
    logic signed [W-1:0] acc_d, acc_q;
    always_comb acc_d = str ? acc_q + din : acc_q;
    always_ff @(posedge clk)
        if (!reset_n || clear) acc_q <= '0;
        else acc_q <= acc_d;
    assign acc = acc_q;
endmodule

// File: rtl/cic_decim_core.sv
// cic_decim_core: N-stage CIC decimator, full-precision internals, truncated output
module cic_decim_core
    import cic_pkg::*;
#(
    parameter int INP_DW = 18,
    parameter int OUT_DW = 18,
    parameter int CIC_R  = 100,
    parameter int CIC_N  = 7,
    parameter int CIC_M  = 1
) (
    input logic              clk,
    input logic              reset_n,
    input logic              clear,
    cic_decim_core_if.slave  inp,
    cic_decim_core_if.master outp
);
    localparam int W  = calc_w(INP_DW, CIC_R, CIC_M, CIC_N);
    localparam int CW = $clog2(CIC_R);

    logic signed [W-1:0]      din [CIC_N];
    logic signed [W-1:0]      acc [CIC_N];
    logic signed [W-1:0]      cx  [CIC_N];
    logic signed [W-1:0]      y   [CIC_N];
    logic [CIC_N:0]           s;
    logic                     last;
    logic [CW-1:0]            cnt_d, cnt_q;
    logic signed [W-1:0]      ds_data_d, ds_data_q;
    logic                     ds_str_d, ds_str_q;
    logic [CIC_N-1:0]         str_d, str_q;
    logic signed [OUT_DW-1:0] out_data_d, out_data_q;
    logic                     out_str_d, out_str_q;

    // Each integrator feeds from the previous stage's registered value
    for (genvar k = 0; k < CIC_N; k++) begin : g_int
        if (k == 0) begin : g_first
            assign din[k] = {{(W-INP_DW){inp.data[INP_DW-1]}}, inp.data};
            assign cx[k]  = ds_data_q;
        end else begin : g_rest
            assign din[k] = acc[k-1];
            assign cx[k]  = y[k-1];
        end
        cic_integrator_stage #(.W(W)) u_int (
            .clk(clk), .reset_n(reset_n), .clear(clear),
            .str(inp.str), .din(din[k]), .acc(acc[k])
        );
        cic_comb_stage #(.W(W), .M(CIC_M)) u_comb (
            .clk(clk), .reset_n(reset_n), .clear(clear),
            .str(s[k]), .x(cx[k]), .y(y[k])
        );
    end

    always_comb begin
        last       = cnt_q == CW'(CIC_R - 1);
        cnt_d      = inp.str ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        ds_str_d   = inp.str && last;
        ds_data_d  = ds_str_d ? acc[CIC_N-1] : ds_data_q;
        s          = {str_q, ds_str_q};
        str_d      = s[CIC_N-1:0];
        out_str_d  = s[CIC_N];
        out_data_d = s[CIC_N] ? y[CIC_N-1][W-1 -: OUT_DW] : out_data_q;
    end

    always_ff @(posedge clk)
        if (!reset_n || clear) begin
            cnt_q      <= '0;
            ds_data_q  <= '0;
            ds_str_q   <= 1'b0;
            str_q      <= '0;
            out_data_q <= '0;
            out_str_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ds_data_q  <= ds_data_d;
            ds_str_q   <= ds_str_d;
            str_q      <= str_d;
            out_data_q <= out_data_d;
            out_str_q  <= out_str_d;
        end

    assign outp.data = out_data_q;
    assign outp.str  = out_str_q;
endmodule

// File: tb/tb_cic_decim_core.sv
// tb_cic_decim_core: three R=4 N=3 decimators (8-bit out, 14-bit out, M=2) on one input stream
module tb_cic_decim_core;
    logic clk, reset_n, clear;
    longint cyc = 0;
    int errors = 0, checks = 0, nstr = 0;

    typedef struct { longint a; longint b; longint c; longint cyc; } exp_t;
    exp_t sb[$];

    cic_decim_core_if #(.DW(8))  in_if ();
    cic_decim_core_if #(.DW(8))  oa ();
    cic_decim_core_if #(.DW(14)) ob ();
    cic_decim_core_if #(.DW(8))  oc ();

    cic_decim_core #(.INP_DW(8), .OUT_DW(8), .CIC_R(4), .CIC_N(3), .CIC_M(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .inp(in_if), .outp(oa));
    cic_decim_core #(.INP_DW(8), .OUT_DW(14), .CIC_R(4), .CIC_N(3), .CIC_M(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .inp(in_if), .outp(ob));
    cic_decim_core #(.INP_DW(8), .OUT_DW(8), .CIC_R(4), .CIC_N(3), .CIC_M(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .clear(clear), .inp(in_if), .outp(oc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-derived unit-step responses: M=1 -> 1,32,63,64..; M=2 -> 1,35,162,350,477,511,512..
    function automatic longint h1(input int k);
        return k == 0 ? 1 : k == 1 ? 32 : k == 2 ? 63 : 64;
    endfunction
    function automatic longint h2(input int k);
        return k == 0 ? 1 : k == 1 ? 35 : k == 2 ? 162 : k == 3 ? 350 :
               k == 4 ? 477 : k == 5 ? 511 : 512;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk)
        if (reset_n && (oa.str || ob.str || oc.str)) begin
            if (sb.size() == 0) check("spurious_str", {oa.str, ob.str, oc.str}, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("str_all", {oa.str, ob.str, oc.str}, 3'b111);
                check("latency", cyc, e.cyc);
                check("out8_m1", oa.data, e.a);
                check("out14_m1", ob.data, e.b);
                check("out8_m2", oc.data, e.c);
            end
        end

    // One strobe every `gap` clks; every 4th strobe since reset/clear yields an output 5 negedges later
    task automatic run(input int x, input int n, input int gap);
        longint xl;
        int k;
        xl = x;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_if.str = 1'b1;
            in_if.data = 8'(x);
            nstr++;
            if (nstr % 4 == 0) begin
                k = nstr / 4 - 1;
                sb.push_back('{(xl * h1(k)) >>> 6, xl * h1(k), (xl * h2(k)) >>> 9, cyc + 5});
            end
            repeat (gap - 1) begin
                @(negedge clk);
                in_if.str = 1'b0;
            end
        end
        @(negedge clk);
        in_if.str = 1'b0;
    endtask

    task automatic do_clear();
        repeat (10) @(negedge clk);
        check("drained", sb.size(), 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_str", {oa.str, ob.str, oc.str}, 0);
        check("clear_data", {oa.data, ob.data, oc.data}, 0);
        nstr = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        clear = 1'b0;
        in_if.str = 1'b0;
        in_if.data = '0;
        repeat (2) @(negedge clk);
        in_if.str = 1'b1;
        in_if.data = 8'sd127;
        repeat (20) begin
            @(negedge clk);
            check("rst_hold", {oa.str, ob.str, oc.str, oa.data, ob.data, oc.data}, 0);
        end
        in_if.str = 1'b0;
        reset_n = 1'b1;
        run(127, 22, 1);
        do_clear();
        run(127, 40, 1);
        do_clear();
        run(-128, 40, 1);
        do_clear();
        run(1, 40, 2);
        do_clear();
        run(127, 10000, 1);
        repeat (10) @(negedge clk);
        check("final_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
